// File: rtl/axil_master.sv
// axil_master: single-outstanding AXI4-Lite master that turns requester commands into AXI reads/writes.
// Optional response watchdog (TIMEOUT_CYCLES) is built only when AXIL_MASTER_TIMEOUT_EN is defined.
module axil_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  // state | meaning
  // IDLE  | waiting for a command, cmd_ready high
  // WRITE | AW/W in flight, bready high, waiting for B
  // READ  | AR in flight, rready high, waiting for R
  // RESP  | response held on rsp_* until rsp_ready
  // DRAIN | watchdog fired: response offered, late B/R still to be absorbed

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
`ifdef AXIL_MASTER_TIMEOUT_EN
    S_DRAIN,
`endif
    S_RESP
  } state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t state_q, state_d;

  logic aw_hs, w_hs, ar_hs, b_hs, r_hs, rsp_hs;

  assign aw_hs  = m_axi_awvalid & m_axi_awready;
  assign w_hs   = m_axi_wvalid  & m_axi_wready;
  assign ar_hs  = m_axi_arvalid & m_axi_arready;
  assign b_hs   = m_axi_bready  & m_axi_bvalid;
  assign r_hs   = m_axi_rready  & m_axi_rvalid;
  assign rsp_hs = rsp_valid     & rsp_ready;

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] to_cnt;
  logic             to_hit;
  logic             rsp_to_q;
  logic             late_ok;
  logic             rsp_ok;

  assign to_hit = (to_cnt == CNT_W'(TIMEOUT_CYCLES));

  // DRAIN may leave once no B/R is still owed and the requester has taken the timeout response
  assign late_ok = !((m_axi_bready & ~m_axi_bvalid) | (m_axi_rready & ~m_axi_rvalid));
  assign rsp_ok  = !rsp_valid | rsp_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      to_cnt <= '0;
    end else if (state_q == S_WRITE || state_q == S_READ) begin
      if (!to_hit) begin
        to_cnt <= to_cnt + 1'b1;
      end
    end else begin
      to_cnt <= '0;
    end
  end

  assign rsp_timeout = rsp_to_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d = cmd_write ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        if (b_hs) begin
          state_d = S_RESP;
        end
`ifdef AXIL_MASTER_TIMEOUT_EN
        else if (to_hit) begin
          state_d = S_DRAIN;
        end
`endif
      end
      S_READ: begin
        if (r_hs) begin
          state_d = S_RESP;
        end
`ifdef AXIL_MASTER_TIMEOUT_EN
        else if (to_hit) begin
          state_d = S_DRAIN;
        end
`endif
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
`ifdef AXIL_MASTER_TIMEOUT_EN
      S_DRAIN: begin
        if (late_ok && rsp_ok) begin
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready = resetn & (state_q == S_IDLE);

  // Handshakes retire their own valid/ready regardless of state; the case below only sets them.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= 2'b00;
`ifdef AXIL_MASTER_TIMEOUT_EN
      rsp_to_q      <= 1'b0;
`endif
    end else begin
      if (aw_hs)  m_axi_awvalid <= 1'b0;
      if (w_hs)   m_axi_wvalid  <= 1'b0;
      if (ar_hs)  m_axi_arvalid <= 1'b0;
      if (b_hs)   m_axi_bready  <= 1'b0;
      if (r_hs)   m_axi_rready  <= 1'b0;
      if (rsp_hs) rsp_valid     <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            if (cmd_write) begin
              m_axi_awaddr  <= cmd_addr;
              m_axi_wdata   <= cmd_wdata;
              m_axi_wstrb   <= cmd_wstrb;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              m_axi_bready  <= 1'b1;
            end else begin
              m_axi_araddr  <= cmd_addr;
              m_axi_arvalid <= 1'b1;
              m_axi_rready  <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (b_hs) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_resp  <= m_axi_bresp;
`ifdef AXIL_MASTER_TIMEOUT_EN
            rsp_to_q  <= 1'b0;
          end else if (to_hit) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_resp  <= 2'b10;
            rsp_to_q  <= 1'b1;
`endif
          end
        end
        S_READ: begin
          if (r_hs) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= m_axi_rdata;
            rsp_resp  <= m_axi_rresp;
`ifdef AXIL_MASTER_TIMEOUT_EN
            rsp_to_q  <= 1'b0;
          end else if (to_hit) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_resp  <= 2'b10;
            rsp_to_q  <= 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_master.sv
// tb_axil_master: directed bench for axil_master with a reactive AXI4-Lite slave and a response model.
// The watchdog scenario is included when AXIL_MASTER_TIMEOUT_EN is defined.
module tb_axil_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [3:0]    cmd_wstrb = '0;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic          m_axi_awvalid, m_axi_awready = 1'b0;
  logic [DW-1:0] m_axi_wdata;
  logic [3:0]    m_axi_wstrb;
  logic          m_axi_wvalid, m_axi_wready = 1'b0;
  logic [1:0]    m_axi_bresp = 2'b00;
  logic          m_axi_bvalid = 1'b0, m_axi_bready;
  logic          m_axi_arvalid, m_axi_arready = 1'b0;
  logic [DW-1:0] m_axi_rdata = '0;
  logic [1:0]    m_axi_rresp = 2'b00;
  logic          m_axi_rvalid = 1'b0, m_axi_rready;

  always #5 clk = ~clk;

  axil_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  int nchk = 0;
  int nfail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // slave behaviour knobs: cycles of ready stall per channel, response delay after request done
  int          aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = '0;
  int          b_cnt = 0, r_cnt = 0;

  // expected transaction, derived from the command and the slave's answer
  logic [31:0] exp_addr = '0, exp_wdata = '0, exp_rdata = '0;
  logic [3:0]  exp_wstrb = '0;
  logic [1:0]  exp_resp = '0;
  logic        exp_to = 1'b0;

  initial begin
    int  aw_age, w_age, ar_age, b_age, r_age;
    bit  aw_done, w_done, ar_done;
    bit  s_pawv, s_pwv, s_parv, s_pbr, s_prr;
    aw_age = 0; w_age = 0; ar_age = 0; b_age = 0; r_age = 0;
    aw_done = 0; w_done = 0; ar_done = 0;
    s_pawv = 0; s_pwv = 0; s_parv = 0; s_pbr = 0; s_prr = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
        m_axi_bvalid = 0; m_axi_rvalid = 0;
        aw_age = 0; w_age = 0; ar_age = 0; b_age = 0; r_age = 0;
        aw_done = 0; w_done = 0; ar_done = 0;
        s_pawv = 0; s_pwv = 0; s_parv = 0; s_pbr = 0; s_prr = 0;
      end else begin
        if (s_pawv && m_axi_awready) aw_done = 1;
        if (s_pwv && m_axi_wready) w_done = 1;
        if (s_parv && m_axi_arready) ar_done = 1;
        if (s_pbr && m_axi_bvalid) begin
          m_axi_bvalid = 0; b_cnt++;
          aw_done = 0; w_done = 0; aw_age = 0; w_age = 0; b_age = 0;
        end
        if (s_prr && m_axi_rvalid) begin
          m_axi_rvalid = 0; r_cnt++;
          ar_done = 0; ar_age = 0; r_age = 0;
        end
        if (m_axi_awvalid && !aw_done) begin aw_age++; m_axi_awready = (aw_age > aw_dly); end
        else m_axi_awready = 0;
        if (m_axi_wvalid && !w_done) begin w_age++; m_axi_wready = (w_age > w_dly); end
        else m_axi_wready = 0;
        if (m_axi_arvalid && !ar_done) begin ar_age++; m_axi_arready = (ar_age > ar_dly); end
        else m_axi_arready = 0;
        if (aw_done && w_done && !m_axi_bvalid) begin
          b_age++;
          if (b_age > b_dly) begin m_axi_bvalid = 1; m_axi_bresp = bresp_cfg; end
        end
        if (ar_done && !m_axi_rvalid) begin
          r_age++;
          if (r_age > r_dly) begin
            m_axi_rvalid = 1; m_axi_rdata = rdata_cfg; m_axi_rresp = rresp_cfg;
          end
        end
        s_pawv = m_axi_awvalid; s_pwv = m_axi_wvalid; s_parv = m_axi_arvalid;
        s_pbr = m_axi_bready; s_prr = m_axi_rready;
      end
    end
  end

  // Per-cycle compare against the model: payloads, response contents, hold-until-handshake rules.
  initial begin
    logic        p_awv, p_wv, p_arv, p_rspv, p_to;
    logic [31:0] p_awaddr, p_wdata, p_araddr, p_rdata;
    logic [3:0]  p_wstrb;
    logic [1:0]  p_resp;
    p_awv = 0; p_wv = 0; p_arv = 0; p_rspv = 0; p_to = 0;
    p_awaddr = 0; p_wdata = 0; p_araddr = 0; p_rdata = 0; p_wstrb = 0; p_resp = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!resetn) begin
        p_awv = 0; p_wv = 0; p_arv = 0; p_rspv = 0;
      end else begin
        if (p_awv && !m_axi_awready) begin
          chk("awvalid_held", m_axi_awvalid, 1);
          chk("awaddr_stable", m_axi_awaddr, p_awaddr);
        end
        if (p_wv && !m_axi_wready) begin
          chk("wvalid_held", m_axi_wvalid, 1);
          chk("wdata_stable", {m_axi_wstrb, m_axi_wdata}, {p_wstrb, p_wdata});
        end
        if (p_arv && !m_axi_arready) begin
          chk("arvalid_held", m_axi_arvalid, 1);
          chk("araddr_stable", m_axi_araddr, p_araddr);
        end
        if (p_rspv && !rsp_ready) begin
          chk("rsp_valid_held", rsp_valid, 1);
          chk("rsp_stable", {rsp_to_bit(rsp_timeout), rsp_resp, rsp_rdata}, {p_to, p_resp, p_rdata});
        end
        if (m_axi_awvalid) chk("awaddr", m_axi_awaddr, exp_addr);
        if (m_axi_wvalid)  chk("wdata_wstrb", {m_axi_wstrb, m_axi_wdata}, {exp_wstrb, exp_wdata});
        if (m_axi_arvalid) chk("araddr", m_axi_araddr, exp_addr);
        if (rsp_valid) begin
          chk("rsp_rdata", rsp_rdata, exp_rdata);
          chk("rsp_resp", rsp_resp, exp_resp);
          chk("rsp_timeout", rsp_timeout, exp_to);
        end
        if (rsp_valid || m_axi_awvalid || m_axi_wvalid || m_axi_arvalid)
          chk("cmd_ready_busy", cmd_ready, 0);
        p_awv = m_axi_awvalid; p_awaddr = m_axi_awaddr;
        p_wv = m_axi_wvalid; p_wdata = m_axi_wdata; p_wstrb = m_axi_wstrb;
        p_arv = m_axi_arvalid; p_araddr = m_axi_araddr;
        p_rspv = rsp_valid; p_rdata = rsp_rdata; p_resp = rsp_resp; p_to = rsp_timeout;
      end
    end
  end

  function automatic logic rsp_to_bit(input logic v);
    return v;
  endfunction

  task automatic start_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic to);
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
    exp_addr = a; exp_wdata = d; exp_wstrb = s; exp_to = to;
    exp_resp  = to ? 2'b10 : (w ? bresp_cfg : rresp_cfg);
    exp_rdata = (w || to) ? 32'h0 : rdata_cfg;
  endtask

  // Returns at the first falling edge after the accepting rising edge.
  task automatic wait_accept();
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accepted", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // lat counts falling edges after the accept edge; arv counts those with arvalid high.
  task automatic wait_rsp(input int start, output int lat, output int arv);
    lat = start;
    arv = 0;
    while (!rsp_valid && lat < 80) begin
      if (m_axi_arvalid) arv++;
      @(negedge clk);
      lat++;
    end
    chk("rsp_arrives", rsp_valid, 1);
  endtask

  task automatic rsp_take();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_cleared", rsp_valid, 0);
  endtask

  initial begin
    int lat, arv, b0, n;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, rsp_valid}, 0);
    chk("rst_readies", {m_axi_bready, m_axi_rready}, 0);
    chk("rst_addrs", {m_axi_awaddr, m_axi_araddr}, 0);
    chk("rst_wdata", {m_axi_wstrb, m_axi_wdata}, 0);
    chk("rst_rsp", {rsp_timeout, rsp_resp, rsp_rdata}, 0);
    resetn = 1'b1;
    @(negedge clk);
    chk("idle_cmd_ready", cmd_ready, 1);

    // write, slave always ready, B next cycle
    start_cmd(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
    wait_accept();
    chk("t1_awaddr", m_axi_awaddr, 32'h10);
    chk("t1_wdata", m_axi_wdata, 32'hDEADBEEF);
    chk("t1_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b111);
    wait_rsp(1, lat, arv);
    chk("t1_latency", lat, 3);
    chk("t1_resp", {rsp_resp, rsp_rdata}, 34'h0);
    rsp_take();

    // read with arready held off 4 cycles
    ar_dly = 4; rdata_cfg = 32'h12345678; rresp_cfg = 2'b00;
    start_cmd(1'b0, 32'h14, 32'h0, 4'h0, 1'b0);
    wait_accept();
    chk("t2_araddr", m_axi_araddr, 32'h14);
    chk("t2_rready", m_axi_rready, 1);
    wait_rsp(1, lat, arv);
    chk("t2_arvalid_cycles", arv, 5);
    chk("t2_latency", lat, 7);
    chk("t2_rdata", rsp_rdata, 32'h12345678);
    rsp_take();
    ar_dly = 0;

    // W accepted 3 cycles before AW, slave answers SLVERR
    aw_dly = 3; bresp_cfg = 2'b10; b0 = b_cnt;
    start_cmd(1'b1, 32'h18, 32'hCAFEF00D, 4'b0101, 1'b0);
    wait_accept();
    @(negedge clk);
    chk("t3_w_first", {m_axi_awvalid, m_axi_wvalid}, 2'b10);
    wait_rsp(2, lat, arv);
    chk("t3_latency", lat, 6);
    chk("t3_bresp", rsp_resp, 2'b10);
    rsp_take();
    repeat (3) @(negedge clk);
    chk("t3_one_b", b_cnt - b0, 1);
    aw_dly = 0;

    // response back-pressure with the next command already waiting
    bresp_cfg = 2'b01;
    start_cmd(1'b1, 32'h20, 32'h0BADF00D, 4'b0011, 1'b0);
    wait_accept();
    wait_rsp(1, lat, arv);
    chk("t4_latency", lat, 3);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h24;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_cmd_blocked", cmd_ready, 0);
      chk("t4_rsp_held", {rsp_valid, rsp_resp}, 3'b101);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("t4_ready_after", {cmd_ready, rsp_valid}, 2'b10);
    rdata_cfg = 32'h000055AA;
    start_cmd(1'b0, 32'h24, 32'h0, 4'h0, 1'b0);
    wait_accept();
    chk("t4_next_accepted", m_axi_arvalid, 1);
    wait_rsp(1, lat, arv);
    chk("t4_read_latency", lat, 3);
    rsp_take();

    // reset while AR is pending
    ar_dly = 10;
    start_cmd(1'b0, 32'h30, 32'h0, 4'h0, 1'b0);
    wait_accept();
    @(negedge clk);
    chk("t5_ar_pending", m_axi_arvalid, 1);
    resetn = 1'b0;
    #1;
    chk("t5_async_drop", {m_axi_arvalid, m_axi_rready, rsp_valid, cmd_ready}, 4'b0000);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    ar_dly = 0; rdata_cfg = 32'hA5A50001;
    @(negedge clk);
    chk("t5_idle", cmd_ready, 1);
    start_cmd(1'b0, 32'h34, 32'h0, 4'h0, 1'b0);
    wait_accept();
    wait_rsp(1, lat, arv);
    chk("t5_latency", lat, 3);
    chk("t5_rdata", rsp_rdata, 32'hA5A50001);
    rsp_take();

`ifdef AXIL_MASTER_TIMEOUT_EN
    // silent slave: watchdog answers, late B is absorbed in the background
    bresp_cfg = 2'b00; b_dly = 18; b0 = b_cnt;
    start_cmd(1'b1, 32'h40, 32'h11223344, 4'hF, 1'b1);
    wait_accept();
    wait_rsp(1, lat, arv);
    chk("t6_to_latency", lat, TO + 2);
    chk("t6_to_rsp", {rsp_timeout, rsp_resp, rsp_rdata}, {1'b1, 2'b10, 32'h0});
    rsp_take();
    repeat (4) @(negedge clk);
    chk("t6_draining", {cmd_ready, m_axi_bready}, 2'b01);
    n = 0;
    while (!cmd_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("t6_drain_exit", n, 6);
    @(negedge clk);
    chk("t6_late_b", b_cnt - b0, 1);
    chk("t6_no_extra_rsp", rsp_valid, 0);
    b_dly = 0;
    start_cmd(1'b1, 32'h44, 32'h55667788, 4'hF, 1'b0);
    wait_accept();
    wait_rsp(1, lat, arv);
    chk("t6_after_latency", lat, 3);
    chk("t6_after_to", rsp_timeout, 0);
    rsp_take();
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "time limit");
  end

endmodule
